// File: rtl/wts_slot_pkg.sv
// Shared definitions for the Z80-style slot bus initiator: FSM state
// encoding and the strobe phase offsets within one 3-T-state bus cycle.
package wts_slot_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_WAIT,
    ST_FINISH
  } state_t;

  localparam int T_CLKS_DEFAULT = 6;

  // Phase offsets, in clk cycles from the start of T1 (cnt = 0).
  function automatic int ph_t1_mid(input int t_clks);
    return t_clks / 2;
  endfunction

  function automatic int ph_t2_start(input int t_clks);
    return t_clks;
  endfunction

  function automatic int ph_t2_end(input int t_clks);
    return 2 * t_clks - 1;
  endfunction

  function automatic int ph_t3_mid(input int t_clks);
    return 2 * t_clks + t_clks / 2;
  endfunction

  function automatic int ph_cyc_end(input int t_clks);
    return 3 * t_clks - 1;
  endfunction

endpackage

// File: rtl/wts_slot_initiator_if.sv
// Host request/response and cartridge slot signals of the initiator.
// master: the initiator itself; slave: the host plus cartridge side.
interface wts_slot_initiator_if;
  logic        req;
  logic        we;
  logic [15:0] addr;
  logic [7:0]  wdata;
  logic        busy;
  logic        done;
  logic        error;
  logic [7:0]  rdata;
  logic [15:0] slot_a;
  logic [7:0]  slot_d_out;
  logic        slot_d_oe;
  logic [7:0]  slot_d_in;
  logic        slot_nsltsl;
  logic        slot_nmerq;
  logic        slot_nrd;
  logic        slot_nwr;
  logic        slot_nwait;
  logic        slot_nint;
  logic        int_req;

  modport master (
    input  req, we, addr, wdata, slot_d_in, slot_nwait, slot_nint,
    output busy, done, error, rdata, slot_a, slot_d_out, slot_d_oe,
           slot_nsltsl, slot_nmerq, slot_nrd, slot_nwr, int_req
  );

  modport slave (
    output req, we, addr, wdata, slot_d_in, slot_nwait, slot_nint,
    input  busy, done, error, rdata, slot_a, slot_d_out, slot_d_oe,
           slot_nsltsl, slot_nmerq, slot_nrd, slot_nwr, int_req
  );
endinterface

// File: rtl/wts_sync2.sv
// Two-flop synchronizer for negative-logic cartridge inputs; resets to
// the inactive level (1) so nothing looks asserted coming out of reset.
module wts_sync2
  import wts_slot_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  // Shift the asynchronous input through two flops.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: reset forces the idle level, not 0, because the signals are active-low.
    if (reset) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      // NOTE: non-blocking so q takes the pre-edge meta, giving two real stages.
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/wts_slot_initiator.sv
// Slot bus initiator: turns one host read/write request into a 3-T-state
// memory cycle on the cartridge slot, stretchable by slot_nwait with a
// timeout, and forwards the cartridge interrupt.
// Strobe registers are updated on the edge where cnt reaches a phase, so a
// strobe change and the matching cnt value become visible together.
module wts_slot_initiator
  import wts_slot_pkg::*;
#(
  parameter int T_CLKS     = T_CLKS_DEFAULT,
  parameter int WAIT_LIMIT = 255
) (
  input logic               clk,
  input logic               reset,
  wts_slot_initiator_if.master bus
);

  localparam int CNT_W  = $clog2(3 * T_CLKS);
  localparam int WAIT_W = $clog2(WAIT_LIMIT + 1);

  localparam logic [CNT_W-1:0] PH_T1_MID   = CNT_W'(ph_t1_mid(T_CLKS));
  localparam logic [CNT_W-1:0] PH_T2_START = CNT_W'(ph_t2_start(T_CLKS));
  localparam logic [CNT_W-1:0] PH_T2_END   = CNT_W'(ph_t2_end(T_CLKS));
  localparam logic [CNT_W-1:0] PH_T3_MID   = CNT_W'(ph_t3_mid(T_CLKS));
  localparam logic [CNT_W-1:0] PH_CYC_END  = CNT_W'(ph_cyc_end(T_CLKS));
  localparam logic [WAIT_W-1:0] WAIT_LAST  = WAIT_W'(WAIT_LIMIT - 1);

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    cnt_nxt;
  logic [WAIT_W-1:0]   wait_cnt;
  logic                we_q;
  logic                nwait_s;
  logic                nint_s;

  wts_sync2 u_sync_nwait (.clk(clk), .reset(reset), .d(bus.slot_nwait), .q(nwait_s));
  wts_sync2 u_sync_nint  (.clk(clk), .reset(reset), .d(bus.slot_nint),  .q(nint_s));

  assign cnt_nxt     = cnt + 1'b1;
  assign bus.int_req = ~nint_s;

  // Bus-cycle FSM with phase counter; all slot and host outputs registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= ST_IDLE;
      cnt             <= '0;
      wait_cnt        <= '0;
      we_q            <= 1'b0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.error       <= 1'b0;
      bus.rdata       <= '0;
      bus.slot_a      <= '0;
      bus.slot_d_out  <= '0;
      bus.slot_d_oe   <= 1'b0;
      bus.slot_nsltsl <= 1'b1;
      bus.slot_nmerq  <= 1'b1;
      bus.slot_nrd    <= 1'b1;
      bus.slot_nwr    <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.req) begin
            we_q            <= bus.we;
            bus.slot_a      <= bus.addr;
            bus.slot_d_out  <= bus.wdata;
            bus.slot_d_oe   <= bus.we;
            bus.slot_nsltsl <= 1'b0;
            bus.busy        <= 1'b1;
            cnt             <= '0;
            state           <= ST_RUN;
          end
        end

        ST_RUN: begin
          if (cnt == PH_T2_END && !nwait_s) begin
            // Cartridge asks for wait states: hold the phase at end of T2.
            wait_cnt <= '0;
            state    <= ST_WAIT;
          end else if (cnt == PH_CYC_END) begin
            bus.slot_nsltsl <= 1'b1;
            bus.slot_d_oe   <= 1'b0;
            bus.done        <= 1'b1;
            state           <= ST_FINISH;
          end else begin
            cnt <= cnt_nxt;
            if (cnt_nxt == PH_T1_MID) begin
              bus.slot_nmerq <= 1'b0;
              bus.slot_nrd   <= we_q;
            end
            if (cnt_nxt == PH_T2_START && we_q) begin
              bus.slot_nwr <= 1'b0;
            end
            if (cnt_nxt == PH_T3_MID) begin
              if (!we_q) begin
                bus.rdata <= bus.slot_d_in;
              end
              bus.slot_nmerq <= 1'b1;
              bus.slot_nrd   <= 1'b1;
              bus.slot_nwr   <= 1'b1;
            end
          end
        end

        ST_WAIT: begin
          if (nwait_s) begin
            // The step out of T2 end hits no strobe phase, so only cnt moves.
            cnt   <= cnt_nxt;
            state <= ST_RUN;
          end else if (wait_cnt == WAIT_LAST) begin
            // Timeout: release the slot and report, leaving rdata untouched.
            bus.slot_nmerq  <= 1'b1;
            bus.slot_nrd    <= 1'b1;
            bus.slot_nwr    <= 1'b1;
            bus.slot_nsltsl <= 1'b1;
            bus.slot_d_oe   <= 1'b0;
            bus.done        <= 1'b1;
            bus.error       <= 1'b1;
            state           <= ST_FINISH;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        ST_FINISH: begin
          bus.done  <= 1'b0;
          bus.error <= 1'b0;
          bus.busy  <= 1'b0;
          state     <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wts_slot_initiator.sv
// Directed bench for wts_slot_initiator at default parameters.
// Period index p counts clk periods after the accepting edge: p = 0 is the
// period in which cnt = 0, so done appears at p = 3*T (+ wait states),
// i.e. 3*T+1 clk after the period in which req was presented.
module tb_wts_slot_initiator;

  localparam int T      = 6;
  localparam int WL     = 255;
  localparam int T1_MID = T / 2;
  localparam int T2_BEG = T;
  localparam int T2_END = 2 * T - 1;
  localparam int T3_MID = 2 * T + T / 2;
  localparam int CYC    = 3 * T;

  typedef struct {
    logic [7:0] rdata;
    logic       err;
    int         done_p;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   tests = 0;
  int   fails = 0;
  exp_t sb[$];
  logic [7:0] last_rdata = 8'h00;

  wts_slot_initiator_if bus_if ();

  wts_slot_initiator #(.T_CLKS(T), .WAIT_LIMIT(WL)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Phase the DUT should be in at period p when w wait states follow T2 end.
  function automatic int cnt_exp(input int p, input int w);
    if (p <= T2_END) return p;
    if (p <= T2_END + w) return T2_END;
    return p - w;
  endfunction

  // Called at a negedge in an IDLE period; drives the request there.
  // nwait is low in periods [nw_a, nw_a+nw_len); nint falls at nint_p (<0: never).
  task automatic run_cycle(input logic w, input logic [15:0] a, input logic [7:0] wd,
                           input logic [7:0] din, input int nw_a, input int nw_len,
                           input int nint_p, input bit hold, input string tag);
    exp_t e;
    exp_t got;
    int   wst = 0;
    bit   abort = 1'b0;
    int   h;
    int   p = 0;
    int   c;
    int   bad = 0;
    int   int_bad = 0;
    bit   done_seen = 1'b0;
    logic [7:0] ev;
    logic [7:0] ov;
    logic [7:0] first_ov = '0;
    logic [7:0] first_ev = '0;
    logic       ei;

    // nwait seen by the FSM lags the pin by two clk.
    if (nw_len > 0 && nw_a + 2 <= T2_END && T2_END <= nw_a + nw_len + 1) begin
      h = nw_a + nw_len + 2;
      if (h - T2_END > WL) begin
        abort = 1'b1;
        wst   = WL;
      end else begin
        wst = h - T2_END;
      end
    end
    e.err    = abort;
    e.done_p = abort ? (T2_END + 1 + WL) : (CYC + wst);
    e.rdata  = (w || abort) ? last_rdata : din;
    sb.push_back(e);
    last_rdata = e.rdata;

    bus_if.req       = 1'b1;
    bus_if.we        = w;
    bus_if.addr      = a;
    bus_if.wdata     = wd;
    bus_if.slot_d_in = din;
    @(posedge clk);
    #1;
    if (!hold) bus_if.req = 1'b0;

    while (!done_seen && p < 700) begin
      bus_if.slot_nwait = !(p >= nw_a && p < nw_a + nw_len);
      if (nint_p >= 0) bus_if.slot_nint = !(p >= nint_p);
      @(negedge clk);
      ei = (nint_p >= 0) && (p >= nint_p + 2);
      if (bus_if.int_req !== ei) int_bad++;
      if (bus_if.done === 1'b1) begin
        done_seen = 1'b1;
        got = sb.pop_front();
        check({tag, " done_latency"}, p, got.done_p);
        check({tag, " error"}, bus_if.error, got.err);
        check({tag, " rdata"}, bus_if.rdata, got.rdata);
        check({tag, " released"},
              {bus_if.slot_nsltsl, bus_if.slot_nmerq, bus_if.slot_nrd,
               bus_if.slot_nwr, bus_if.slot_d_oe, bus_if.busy}, 6'b111101);
      end else begin
        c  = cnt_exp(p, wst);
        ev = {1'b0,
              !(c >= T1_MID && c < T3_MID),
              w ? 1'b1 : !(c >= T1_MID && c < T3_MID),
              w ? !(c >= T2_BEG && c < T3_MID) : 1'b1,
              w,
              1'b1,
              1'b1,
              w ? 1'b1 : 1'b0};
        ov = {bus_if.slot_nsltsl, bus_if.slot_nmerq, bus_if.slot_nrd, bus_if.slot_nwr,
              bus_if.slot_d_oe, bus_if.busy, bus_if.slot_a === a,
              w ? (bus_if.slot_d_out === wd) : 1'b0};
        if (ov !== ev || bus_if.done !== 1'b0 || (!bus_if.slot_nrd && !bus_if.slot_nwr)) begin
          if (bad == 0) begin
            first_ov = ov;
            first_ev = ev;
          end
          bad++;
        end
        @(posedge clk);
        #1;
        p++;
      end
    end
    if (!done_seen) void'(sb.pop_front());
    check({tag, " done_seen"}, done_seen, 1'b1);
    check({tag, " strobes"}, bad, 0);
    if (bad != 0) $display("  %s first strobe period got %b expected %b", tag, first_ov, first_ev);
    check({tag, " int_req"}, int_bad, 0);
    bus_if.slot_nwait = 1'b1;
    bus_if.slot_nint  = 1'b1;
  endtask

  // One period after a completed cycle: back in IDLE, done gone.
  task automatic idle_check(input string tag);
    @(negedge clk);
    check({tag, " idle"}, {bus_if.busy, bus_if.done, bus_if.error, bus_if.slot_nsltsl},
          4'b0001);
  endtask

  initial begin
    bus_if.req        = 1'b0;
    bus_if.we         = 1'b0;
    bus_if.addr       = '0;
    bus_if.wdata      = '0;
    bus_if.slot_d_in  = '0;
    bus_if.slot_nwait = 1'b1;
    bus_if.slot_nint  = 1'b1;

    // Reset state, checked before any clock edge.
    #1 reset = 1'b1;
    #1;
    check("reset strobes", {bus_if.slot_nsltsl, bus_if.slot_nmerq, bus_if.slot_nrd,
                            bus_if.slot_nwr, bus_if.slot_d_oe, bus_if.busy,
                            bus_if.done, bus_if.error, bus_if.int_req}, 9'b111100000);
    check("reset slot_a", bus_if.slot_a, 16'h0000);
    check("reset rdata", bus_if.rdata, 8'h00);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Plain read and write.
    run_cycle(1'b0, 16'h9800, 8'h00, 8'hA5, 0, 0, -1, 1'b0, "read");
    idle_check("read");
    @(negedge clk);
    run_cycle(1'b1, 16'h9801, 8'h3C, 8'hEE, 0, 0, -1, 1'b0, "write");
    idle_check("write");

    // Read stretched by nwait low for 10 clk around end of T2.
    @(negedge clk);
    run_cycle(1'b0, 16'h4123, 8'h00, 8'h5A, 9, 10, -1, 1'b0, "wait_read");
    idle_check("wait_read");

    // nwait stuck low: timeout abort, rdata keeps the previous read.
    @(negedge clk);
    run_cycle(1'b0, 16'h7FFE, 8'h00, 8'hFF, 0, 100000, -1, 1'b0, "timeout");
    idle_check("timeout");
    repeat (3) @(negedge clk);

    // Reset in the middle of a write.
    bus_if.req   = 1'b1;
    bus_if.we    = 1'b1;
    bus_if.addr  = 16'hC000;
    bus_if.wdata = 8'h77;
    @(posedge clk);
    #1 bus_if.req = 1'b0;
    repeat (9) @(negedge clk);
    check("pre_reset nwr", bus_if.slot_nwr, 1'b0);
    reset = 1'b1;
    #1;
    check("mid_reset outputs", {bus_if.slot_nsltsl, bus_if.slot_nmerq, bus_if.slot_nrd,
                                bus_if.slot_nwr, bus_if.slot_d_oe, bus_if.busy,
                                bus_if.done, bus_if.error}, 8'b11110000);
    check("mid_reset bus", {bus_if.slot_a, bus_if.slot_d_out}, 24'h000000);
    last_rdata = 8'h00;
    @(negedge clk);
    reset = 1'b0;
    begin
      int nd = 0;
      repeat (4) begin
        @(negedge clk);
        if (bus_if.done !== 1'b0 || bus_if.busy !== 1'b0) nd++;
      end
      check("post_reset no_done", nd, 0);
    end
    run_cycle(1'b0, 16'h9800, 8'h00, 8'h11, 0, 0, -1, 1'b0, "after_reset");
    idle_check("after_reset");

    // Interrupt in IDLE: int_req follows two clk after the fall.
    @(negedge clk);
    bus_if.slot_nint = 1'b0;
    @(negedge clk);
    check("int_idle early", bus_if.int_req, 1'b0);
    @(negedge clk);
    check("int_idle", bus_if.int_req, 1'b1);
    bus_if.slot_nint = 1'b1;
    repeat (3) @(negedge clk);
    check("int_idle clear", bus_if.int_req, 1'b0);

    // Interrupt during a cycle, req held across done: back-to-back cycles.
    run_cycle(1'b0, 16'h1234, 8'h00, 8'hC3, 0, 0, 5, 1'b1, "b2b_first");
    idle_check("b2b_gap");
    run_cycle(1'b1, 16'h1235, 8'h96, 8'h00, 0, 0, -1, 1'b0, "b2b_second");
    idle_check("b2b_second");
    check("scoreboard empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Hard stop in case a wait above never returns.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
